// File: rtl/featuremap_layer_sequencer.sv
// Featuremap layer sequencer: walks one zero-padded (WIDTH+2)^2 raster across CH lockstep FIFOs and
// masks the conv stream to WIDTH*WIDTH real outputs. Macro FEATUREMAP_SEQ_STALL_CNT_EN adds stall_cnt.
module featuremap_layer_sequencer #(
    parameter int CH    = 8,
    parameter int WIDTH = 56,
    parameter int CW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CH-1:0] fifo_empty,
    output logic          fifo_rdreq,
    output logic          pix_valid,
    output logic          pix_pad,
    input  logic          conv_valid,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] out_cnt
`ifdef FEATUREMAP_SEQ_STALL_CNT_EN
    ,
    output logic [CW+8-1:0] stall_cnt
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_POS  = CW'(WIDTH + 1);
    localparam logic [CW-1:0] OUT_TOTAL = CW'(WIDTH * WIDTH);
    localparam logic [CW-1:0] OC_FIRST  = CW'(2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t        state_r;
    state_t        next_state_s;
    logic [CW-1:0] row_r;
    logic [CW-1:0] col_r;
    logic [CW-1:0] oc_r;
    logic          armed_r;

    logic feed_s;
    logic active_s;
    logic border_s;
    logic data_ok_s;
    logic issue_s;
    logic last_pix_s;
    logic start_ok_s;
    logic frame_full_s;
    logic clear_s;

    assign feed_s       = (state_r == ST_FEED);
    assign active_s     = (state_r == ST_FEED) || (state_r == ST_DRAIN);
    assign border_s     = (row_r == {CW{1'b0}}) || (row_r == LAST_POS) ||
                          (col_r == {CW{1'b0}}) || (col_r == LAST_POS);
    assign data_ok_s    = ~|fifo_empty;
    assign issue_s      = feed_s && (border_s || data_ok_s);
    assign last_pix_s   = (row_r == LAST_POS) && (col_r == LAST_POS);
    // A start seen on the first edge after reset release is dropped: reset wins.
    assign start_ok_s   = start && armed_r && (state_r == ST_IDLE);
    assign frame_full_s = (out_cnt == OUT_TOTAL);
    assign clear_s      = start_ok_s || (state_r == ST_DONE);

    // Arms start acceptance one cycle after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) armed_r <= 1'b0;
        else      armed_r <= 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= next_state_s;
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) next_state_s = ST_FEED;
                else            next_state_s = ST_IDLE;
            end
            ST_FEED: begin
                if (issue_s && last_pix_s) next_state_s = ST_DRAIN;
                else                       next_state_s = ST_FEED;
            end
            ST_DRAIN: begin
                if (frame_full_s || (out_valid && out_cnt == OUT_TOTAL - CNT_ONE))
                    next_state_s = ST_DONE;
                else
                    next_state_s = ST_DRAIN;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode; rdreq and pix_valid must share the cycle with the FIFO show-ahead data
    always_comb begin
        pix_valid  = issue_s;
        pix_pad    = feed_s && border_s;
        fifo_rdreq = feed_s && !border_s && data_ok_s;
        out_valid  = conv_valid && active_s && (oc_r >= OC_FIRST);
        busy       = (state_r != ST_IDLE);
        done       = (state_r == ST_DONE);
    end

    // Padded raster scan position, column fastest
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_r <= {CW{1'b0}};
            col_r <= {CW{1'b0}};
        end else if (clear_s) begin
            row_r <= {CW{1'b0}};
            col_r <= {CW{1'b0}};
        end else if (issue_s) begin
            if (col_r == LAST_POS) begin
                col_r <= {CW{1'b0}};
                row_r <= row_r + CNT_ONE;
            end else begin
                col_r <= col_r + CNT_ONE;
            end
        end else begin
            row_r <= row_r;
            col_r <= col_r;
        end
    end

    // Output column tracker; the first two columns of each row are wraparound windows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oc_r <= {CW{1'b0}};
        end else if (clear_s) begin
            oc_r <= {CW{1'b0}};
        end else if (active_s && conv_valid) begin
            if (oc_r == LAST_POS) oc_r <= {CW{1'b0}};
            else                  oc_r <= oc_r + CNT_ONE;
        end else begin
            oc_r <= oc_r;
        end
    end

    // Real output count; holds its final value until the next accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt <= {CW{1'b0}};
        end else if (start_ok_s) begin
            out_cnt <= {CW{1'b0}};
        end else if (out_valid && !frame_full_s) begin
            out_cnt <= out_cnt + CNT_ONE;
        end else begin
            out_cnt <= out_cnt;
        end
    end

`ifdef FEATUREMAP_SEQ_STALL_CNT_EN
    logic stall_hit_s;
    assign stall_hit_s = feed_s && !border_s && !data_ok_s;

    // Saturating count of interior cycles stalled on an empty FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= {(CW+8){1'b0}};
        end else if (start_ok_s) begin
            stall_cnt <= {(CW+8){1'b0}};
        end else if (stall_hit_s && (stall_cnt != {(CW+8){1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CW+7){1'b0}}, 1'b1};
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_featuremap_layer_sequencer.sv
// Randomized self-checking bench for featuremap_layer_sequencer (WIDTH=4) against a raster-index model.
`timescale 1ns/1ps
module tb_featuremap_layer_sequencer;
    localparam int CH   = 8;
    localparam int W    = 4;
    localparam int CW   = 12;
    localparam int P    = W + 2;
    localparam int NPIX = P * P;
    localparam int NOUT = W * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          conv_valid = 1'b0;
    logic [CH-1:0] fifo_empty = '0;
    logic          fifo_rdreq, pix_valid, pix_pad, out_valid, busy, done;
    logic [CW-1:0] out_cnt;
`ifdef FEATUREMAP_SEQ_STALL_CNT_EN
    logic [CW+8-1:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1 feeding, 2 draining, 3 done; m_pos is the linear padded raster index
    int m_phase, m_pos, m_conv, m_outs, m_stalls;
    bit m_armed;

    int n_pv, n_pad, n_rd, n_ov, n_hold, cyc, last_pv_cyc, ov16_cyc, done_cyc;

    always #5 clk = ~clk;

    featuremap_layer_sequencer #(.CH(CH), .WIDTH(W), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .pix_valid  (pix_valid),
        .pix_pad    (pix_pad),
        .conv_valid (conv_valid),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .out_cnt    (out_cnt)
`ifdef FEATUREMAP_SEQ_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_conv = 0; m_outs = 0; m_stalls = 0; m_armed = 1'b0;
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model, return just after the rising edge
    task automatic cycle(input bit s, input logic [CH-1:0] e, input bit cv);
        int r, c;
        bit pad, feed, acc, e_pv, e_pad, e_rd, e_ov;
        start = s; fifo_empty = e; conv_valid = cv;
        @(negedge clk);
        if (!rst) model_reset();
        feed = (m_phase == 1);
        r    = m_pos / P;
        c    = m_pos % P;
        pad  = (r == 0) || (r == P - 1) || (c == 0) || (c == P - 1);
        e_pv  = feed && (pad || e == '0);
        e_pad = feed && pad;
        e_rd  = feed && !pad && e == '0;
        acc   = (m_phase == 1 || m_phase == 2) && cv;
        e_ov  = acc && ((m_conv % P) >= 2);
        check_val("pix_valid",  32'(pix_valid),  32'(e_pv));
        check_val("pix_pad",    32'(pix_pad),    32'(e_pad));
        check_val("fifo_rdreq", 32'(fifo_rdreq), 32'(e_rd));
        check_val("out_valid",  32'(out_valid),  32'(e_ov));
        check_val("busy",       32'(busy),       32'(m_phase != 0));
        check_val("done",       32'(done),       32'(m_phase == 3));
        check_val("out_cnt",    32'(out_cnt),    32'(m_outs));
        if (pix_valid) begin n_pv++; last_pv_cyc = cyc; end
        if (pix_valid && pix_pad) n_pad++;
        if (fifo_rdreq) n_rd++;
        if (out_valid) begin n_ov++; if (n_ov == NOUT) ov16_cyc = cyc; end
        if (done) done_cyc = cyc;
        if (feed && !e_pv) n_hold++;
        if (rst) begin
            if (e_ov && m_outs < NOUT) m_outs++;
            if (acc) m_conv++;
            if (feed && !pad && e != '0) m_stalls++;
            case (m_phase)
                0: if (s && m_armed) begin
                       m_phase = 1; m_pos = 0; m_conv = 0; m_outs = 0; m_stalls = 0;
                   end
                1: if (e_pv) begin
                       if (m_pos == NPIX - 1) m_phase = 2;
                       else m_pos++;
                   end
                2: if (m_outs == NOUT) m_phase = 3;
                default: begin m_phase = 0; m_pos = 0; m_conv = 0; end
            endcase
            m_armed = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // mode 0: full FIFOs with start pokes, 1: seven-cycle stall at (2,3), 2: random
    task automatic run_frame(input int mode);
        int stall_left;
        int guard;
        bit s, cv;
        logic [CH-1:0] e;
        stall_left = 7; guard = 0;
        n_pv = 0; n_pad = 0; n_rd = 0; n_ov = 0; n_hold = 0;
        cyc = 0; last_pv_cyc = -1; ov16_cyc = -1; done_cyc = -1;
        cycle(1'b1, '0, 1'b0);
        while (m_phase != 0 && guard < 3000) begin
            s = 1'b0; e = '0; cv = 1'b0;
            case (mode)
                0: begin
                    cv = (m_phase == 2);
                    s  = (m_phase == 1 && m_pos == 10) || (m_phase == 3);
                end
                1: begin
                    cv = (m_phase == 2);
                    if (m_phase == 1 && m_pos == 2 * P + 3 && stall_left > 0) begin
                        e = 8'h20;
                        stall_left--;
                    end
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) e = CH'($urandom_range(1, 255));
                    if (m_phase == 1) cv = ($urandom_range(0, 3) == 0);
                    else cv = 1'($urandom_range(0, 1));
                    s = ($urandom_range(0, 7) == 0);
                end
            endcase
            cycle(s, e, cv);
            guard++;
        end
        check_val("frame_ends", 32'(guard < 3000), 32'd1);
        check_val("pad_count", 32'(n_pad), 32'(NPIX - NOUT));
        check_val("rdreq_count", 32'(n_rd), 32'(NOUT));
        check_val("final_out_cnt", 32'(out_cnt), 32'(NOUT));
        if (mode == 0) begin
            check_val("pv_count", 32'(n_pv), 32'(NPIX));
            check_val("ov_count", 32'(n_ov), 32'(NOUT));
            check_val("last_pv_cycle", 32'(last_pv_cyc), 32'(NPIX));
            check_val("done_after_last_ov", 32'(done_cyc - ov16_cyc), 32'd1);
        end else if (mode == 1) begin
            check_val("pv_count", 32'(n_pv), 32'(NPIX));
            check_val("ov_count", 32'(n_ov), 32'(NOUT));
            check_val("hold_cycles", 32'(n_hold), 32'd7);
`ifdef FEATUREMAP_SEQ_STALL_CNT_EN
            check_val("stall_cnt", 32'(stall_cnt), 32'd7);
`endif
        end else begin
`ifdef FEATUREMAP_SEQ_STALL_CNT_EN
            check_val("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
`endif
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, '0, 1'b1);
        rst = 1'b1;
        cycle(1'b1, '0, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1);

        run_frame(0);

        // Abandon a frame mid-FEED with an asynchronous reset
        cycle(1'b1, '0, 1'b0);
        repeat (8) cycle(1'b0, '0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_val("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        check_val("rst_pix_pad", 32'(pix_pad), 32'd0);
        cycle(1'b0, '0, 1'b0);
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0);

        run_frame(0);
        run_frame(1);
        for (int i = 0; i < 5; i++) run_frame(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
